// File: rtl/audio_buffer_filler.sv
// Producer side of the audio ping-pong buffer: streams sample bytes into the
// bank the codec does not own, zero-pads the final bank, and trades banks via filled/empty.
module audio_buffer_filler #(
  parameter int BUFFER_ADDR_BITS  = 9,
  parameter int BUFFER_SIZE_BYTES = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [7:0]                  stream_data_i,
  input  logic                        stream_valid_i,
  input  logic                        stream_last_i,
  output logic                        stream_ready_o,
  output logic                        buf_wr_en_o,
  output logic                        buf_wr_sel_o,
  output logic [BUFFER_ADDR_BITS-1:0] buf_wr_addr_o,
  output logic [7:0]                  buf_wr_data_o,
  output logic                        buf_filled_o,
  input  logic                        buf_empty_i,
  output logic                        buf_empty_ack_o,
  output logic                        done_o
);

  typedef enum logic [2:0] {IDLE, FILL, PAD, FULL, DONE} state_t;

  localparam logic [BUFFER_ADDR_BITS-1:0] LAST_ADDR = BUFFER_ADDR_BITS'(BUFFER_SIZE_BYTES - 1);
  localparam logic [BUFFER_ADDR_BITS-1:0] ADDR_ONE  = BUFFER_ADDR_BITS'(1);

  state_t                      state;
  logic [BUFFER_ADDR_BITS-1:0] waddr;
  logic                        eos;
  logic                        accept;
  logic                        empty_req;

  assign stream_ready_o = (state == FILL);
  assign accept         = stream_valid_i && stream_ready_o;
  // The consumer drops its request one cycle after the ack, so that cycle is ignored.
  assign empty_req      = buf_empty_i && !buf_empty_ack_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      waddr           <= '0;
      eos             <= 1'b0;
      buf_wr_en_o     <= 1'b0;
      buf_wr_sel_o    <= 1'b1;
      buf_wr_addr_o   <= '0;
      buf_wr_data_o   <= 8'h00;
      buf_filled_o    <= 1'b0;
      buf_empty_ack_o <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      buf_wr_en_o     <= 1'b0;
      buf_empty_ack_o <= empty_req;
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= FILL;
            waddr  <= '0;
            eos    <= 1'b0;
            done_o <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            buf_wr_en_o   <= 1'b1;
            buf_wr_addr_o <= waddr;
            buf_wr_data_o <= stream_data_i;
            if (waddr == LAST_ADDR) begin
              state        <= FULL;
              buf_filled_o <= 1'b1;
              waddr        <= '0;
              if (stream_last_i) eos <= 1'b1;
            end else begin
              waddr <= waddr + ADDR_ONE;
              if (stream_last_i) begin
                state <= PAD;
                eos   <= 1'b1;
              end
            end
          end
        end
        PAD: begin
          buf_wr_en_o   <= 1'b1;
          buf_wr_addr_o <= waddr;
          buf_wr_data_o <= 8'h00;
          if (waddr == LAST_ADDR) begin
            state        <= FULL;
            buf_filled_o <= 1'b1;
            waddr        <= '0;
          end else begin
            waddr <= waddr + ADDR_ONE;
          end
        end
        FULL: begin
          // Bank handover: the consumer takes the full bank, we move to the other one.
          if (empty_req) begin
            buf_filled_o <= 1'b0;
            buf_wr_sel_o <= ~buf_wr_sel_o;
            waddr        <= '0;
            if (eos) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        DONE: begin
          if (start_i) begin
            state  <= FILL;
            waddr  <= '0;
            eos    <= 1'b0;
            done_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
